i2s_capture_sched: RTL and testbench

//  Sequencer between the I2S receiver and the 32x16 sample FIFO. Enables the receiver,

---
 rtl/i2s_capture_sched.sv | 146 ++++++++++++++
 tb/tb_i2s_capture_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_capture_sched.sv
// I2S capture sequencer: aligns to a left-channel frame, filters and decimates samples,
// writes one block into the sample FIFO, then holds until the host acknowledges it.
module i2s_capture_sched #(
   parameter int DW   = 32,
   parameter int CW   = 16,
   parameter int DECW = 4
) (
   input  logic            HCLK,
   input  logic            HRESET,
   input  logic            cfg_en,
   input  logic [1:0]      cfg_chan,
   input  logic [DECW-1:0] cfg_decim,
   input  logic [CW-1:0]   cfg_blk_len,
   input  logic            cfg_cont,
   input  logic            start,
   input  logic            ack,
   output logic            i2s_en,
   input  logic            smp_valid,
   input  logic            smp_ws,
   input  logic [DW-1:0]   smp_data,
   input  logic            fifo_full,
   output logic            fifo_wr,
   output logic [DW-1:0]   fifo_wdata,
   output logic            blk_done,
   output logic            overrun,
   output logic            busy,
   output logic [CW-1:0]   wr_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   state_t          state_r;
   logic [1:0]      chan_r;
   logic [DECW-1:0] decim_r;
   logic [DECW-1:0] dcnt_r;
   logic [CW-1:0]   blk_len_r;
   logic            cont_r;
   logic            pass_s;
   logic [CW-1:0]   wr_next_s;

   // Channel filter on the latched selection and the post-write block count
   always_comb begin
      pass_s = 1'b0;
      if (chan_r[1]) begin
         pass_s = 1'b1;
      end else if (smp_ws == chan_r[0]) begin
         pass_s = 1'b1;
      end else begin
         pass_s = 1'b0;
      end
      wr_next_s = wr_count + {{(CW-1){1'b0}}, 1'b1};
   end

   // Sequencer state, latched configuration and all registered outputs
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_r    <= ST_IDLE;
         chan_r     <= 2'b00;
         decim_r    <= {DECW{1'b0}};
         dcnt_r     <= {DECW{1'b0}};
         blk_len_r  <= {CW{1'b0}};
         cont_r     <= 1'b0;
         i2s_en     <= 1'b0;
         fifo_wr    <= 1'b0;
         fifo_wdata <= {DW{1'b0}};
         blk_done   <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
         wr_count   <= {CW{1'b0}};
      end else begin
         fifo_wr <= 1'b0;
         // Dropping the master enable beats any same-cycle write or ack
         if ((state_r != ST_IDLE) && !cfg_en) begin
            state_r  <= ST_IDLE;
            i2s_en   <= 1'b0;
            busy     <= 1'b0;
            blk_done <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (start && cfg_en && (cfg_blk_len != {CW{1'b0}})) begin
                     chan_r    <= cfg_chan;
                     decim_r   <= cfg_decim;
                     blk_len_r <= cfg_blk_len;
                     cont_r    <= cfg_cont;
                     wr_count  <= {CW{1'b0}};
                     overrun   <= 1'b0;
                     i2s_en    <= 1'b1;
                     busy      <= 1'b1;
                     state_r   <= ST_ARM;
                  end
               end
               ST_ARM: begin
                  // The aligning left sample itself is never stored
                  if (smp_valid && !smp_ws) begin
                     dcnt_r  <= {DECW{1'b0}};
                     state_r <= ST_CAPTURE;
                  end
               end
               ST_CAPTURE: begin
                  if (smp_valid && pass_s) begin
                     if (dcnt_r == {DECW{1'b0}}) begin
                        dcnt_r <= decim_r;
                        if (fifo_full) begin
                           overrun <= 1'b1;
                        end else begin
                           fifo_wr    <= 1'b1;
                           fifo_wdata <= smp_data;
                           wr_count   <= wr_next_s;
                           if (wr_next_s == blk_len_r) begin
                              blk_done <= 1'b1;
                              state_r  <= ST_HOLD;
                           end
                        end
                     end else begin
                        dcnt_r <= dcnt_r - {{(DECW-1){1'b0}}, 1'b1};
                     end
                  end
               end
               ST_HOLD: begin
                  if (ack) begin
                     blk_done <= 1'b0;
                     wr_count <= {CW{1'b0}};
                     if (cont_r) begin
                        state_r <= ST_ARM;
                     end else begin
                        i2s_en  <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                     end
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2s_capture_sched.sv
// Randomised bench for i2s_capture_sched; expected block contents come from a
// sample-list model (alignment, channel filter, modulo decimation, full drops).
module tb_i2s_capture_sched;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        cfg_en = 1'b0;
   logic [1:0]  cfg_chan = 2'b00;
   logic [3:0]  cfg_decim = 4'd0;
   logic [15:0] cfg_blk_len = 16'd0;
   logic        cfg_cont = 1'b0;
   logic        start = 1'b0;
   logic        ack = 1'b0;
   logic        i2s_en;
   logic        smp_valid = 1'b0;
   logic        smp_ws = 1'b0;
   logic [31:0] smp_data = 32'd0;
   logic        fifo_full = 1'b0;
   logic        fifo_wr;
   logic [31:0] fifo_wdata;
   logic        blk_done;
   logic        overrun;
   logic        busy;
   logic [15:0] wr_count;

   int n_checks = 0;
   int n_errors = 0;

   logic        ws_q[$];
   logic [31:0] data_q[$];
   logic        full_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];

   i2s_capture_sched dut (
      .HCLK(HCLK), .HRESET(HRESET), .cfg_en(cfg_en), .cfg_chan(cfg_chan),
      .cfg_decim(cfg_decim), .cfg_blk_len(cfg_blk_len), .cfg_cont(cfg_cont),
      .start(start), .ack(ack), .i2s_en(i2s_en), .smp_valid(smp_valid),
      .smp_ws(smp_ws), .smp_data(smp_data), .fifo_full(fifo_full),
      .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .blk_done(blk_done),
      .overrun(overrun), .busy(busy), .wr_count(wr_count)
   );

   always #5 HCLK = ~HCLK;

   // Collect every FIFO write just after the edge that produced it
   always @(posedge HCLK) begin
      #1;
      if (fifo_wr === 1'b1) obs_q.push_back(fifo_wdata);
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, ".i2s_en"}, i2s_en, 1'b0);
      check_eq({tag, ".fifo_wr"}, fifo_wr, 1'b0);
      check_eq({tag, ".fifo_wdata"}, fifo_wdata, 32'd0);
      check_eq({tag, ".blk_done"}, blk_done, 1'b0);
      check_eq({tag, ".overrun"}, overrun, 1'b0);
      check_eq({tag, ".busy"}, busy, 1'b0);
      check_eq({tag, ".wr_count"}, wr_count, 16'd0);
   endtask

   // Expected writes for one armed block given the sample list in ws_q/data_q/full_q
   task automatic model(input logic [1:0] ch, input int dc, input int bl, output bit done, output bit ov);
      bit aligned = 0;
      int passed = 0;
      exp_q.delete();
      ov = 0;
      foreach (ws_q[i]) begin
         if (exp_q.size() == bl) break;
         if (!aligned) begin
            if (ws_q[i] == 1'b0) aligned = 1;
            continue;
         end
         if (!(ch[1] || (ws_q[i] == ch[0]))) continue;
         if (passed % (dc + 1) == 0) begin
            if (full_q[i]) ov = 1;
            else exp_q.push_back(data_q[i]);
         end
         passed++;
      end
      done = (exp_q.size() == bl);
   endtask

   task automatic push_smp(input logic ws, input logic [31:0] d, input logic full);
      ws_q.push_back(ws);
      data_q.push_back(d);
      full_q.push_back(full);
   endtask

   task automatic clear_stream();
      ws_q.delete();
      data_q.delete();
      full_q.delete();
   endtask

   task automatic gen_random(input int n, input int pfull);
      clear_stream();
      for (int i = 0; i < n; i++)
         push_smp(1'($urandom), $urandom, ($urandom_range(0, 99) < pfull));
   endtask

   task automatic send_stream();
      for (int i = 0; i < ws_q.size(); i++) begin
         @(negedge HCLK);
         smp_valid = 1'b1;
         smp_ws    = ws_q[i];
         smp_data  = data_q[i];
         fifo_full = full_q[i];
         repeat ($urandom_range(0, 2)) begin
            @(negedge HCLK);
            smp_valid = 1'b0;
            fifo_full = 1'($urandom);
         end
      end
      @(negedge HCLK);
      smp_valid = 1'b0;
      fifo_full = 1'b0;
      repeat (2) @(negedge HCLK);
   endtask

   task automatic do_start(input logic [1:0] ch, input logic [3:0] dc, input logic [15:0] bl, input logic cont);
      @(negedge HCLK);
      cfg_chan = ch; cfg_decim = dc; cfg_blk_len = bl; cfg_cont = cont; start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      cfg_chan = 2'($urandom); cfg_decim = 4'($urandom); cfg_blk_len = 16'($urandom); cfg_cont = 1'($urandom);
      check_eq("start.busy", busy, 1'b1);
      check_eq("start.i2s_en", i2s_en, 1'b1);
      check_eq("start.overrun_clr", overrun, 1'b0);
      check_eq("start.wr_count_clr", wr_count, 16'd0);
   endtask

   task automatic run_block(input logic [1:0] ch, input int dc, input int bl, inout bit ov_acc, output bit done);
      bit ov;
      model(ch, dc, bl, done, ov);
      ov_acc = ov_acc | ov;
      obs_q.delete();
      send_stream();
      check_eq("blk.n_writes", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < obs_q.size()) check_eq("blk.wdata", obs_q[i], exp_q[i]);
      check_eq("blk.wr_count", wr_count, exp_q.size());
      check_eq("blk.blk_done", blk_done, done);
      check_eq("blk.overrun", overrun, ov_acc);
      check_eq("blk.busy", busy, 1'b1);
   endtask

   task automatic do_ack(input logic cont);
      @(negedge HCLK); ack = 1'b1;
      @(negedge HCLK); ack = 1'b0;
      check_eq("ack.blk_done", blk_done, 1'b0);
      check_eq("ack.wr_count", wr_count, 16'd0);
      check_eq("ack.busy", busy, cont);
      check_eq("ack.i2s_en", i2s_en, cont);
   endtask

   task automatic do_abort();
      @(negedge HCLK); cfg_en = 1'b0;
      @(negedge HCLK); cfg_en = 1'b1;
      check_eq("abort.busy", busy, 1'b0);
      check_eq("abort.i2s_en", i2s_en, 1'b0);
      check_eq("abort.blk_done", blk_done, 1'b0);
   endtask

   initial begin
      bit done;
      bit ov_acc;
      logic [1:0] ch;
      int dc, bl, pfull;
      logic cont;

      repeat (3) @(negedge HCLK);
      HRESET = 1'b0;
      @(negedge HCLK);
      check_idle_outputs("reset");
      cfg_en = 1'b1;

      // Left-only, no decimation: R/L interleave after the aligning L0
      do_start(2'b00, 4'd0, 16'd4, 1'b0);
      clear_stream();
      push_smp(1'b0, 32'hA0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         push_smp(1'b1, 32'hB0 + 32'(i), 1'b0);
         push_smp(1'b0, 32'hA0 + 32'(i), 1'b0);
      end
      push_smp(1'b0, 32'hA5, 1'b0);
      ov_acc = 0;
      run_block(2'b00, 0, 4, ov_acc, done);
      check_eq("t1.first_is_L1", (obs_q.size() > 0) ? obs_q[0] : 32'hX, 32'hA1);
      do_ack(1'b0);

      // Both channels, keep one in three; stray start/ack in ARM must not disturb
      do_start(2'b10, 4'd2, 16'd3, 1'b0);
      @(negedge HCLK); cfg_blk_len = 16'd1; start = 1'b1; ack = 1'b1;
      @(negedge HCLK); start = 1'b0; ack = 1'b0;
      check_eq("t2.busy_after_stray", busy, 1'b1);
      clear_stream();
      push_smp(1'b0, 32'hC000, 1'b0);
      for (int i = 0; i < 9; i++) push_smp(1'(i + 1), 32'hC100 + 32'(i), 1'b0);
      ov_acc = 0;
      run_block(2'b10, 2, 3, ov_acc, done);
      check_eq("t2.hold", blk_done, 1'b1);
      do_ack(1'b0);

      // FIFO full for the first two candidates
      do_start(2'b00, 4'd0, 16'd2, 1'b0);
      clear_stream();
      push_smp(1'b0, 32'hD0, 1'b0);
      push_smp(1'b0, 32'hD1, 1'b1);
      push_smp(1'b0, 32'hD2, 1'b1);
      push_smp(1'b0, 32'hD3, 1'b0);
      push_smp(1'b0, 32'hD4, 1'b0);
      ov_acc = 0;
      run_block(2'b00, 0, 2, ov_acc, done);
      do_ack(1'b0);
      check_eq("t3.overrun_sticky", overrun, 1'b1);

      // Continuous mode: two blocks, then abort
      do_start(2'b01, 4'd0, 16'd2, 1'b1);
      ov_acc = 0;
      for (int r = 0; r < 2; r++) begin
         gen_random(12, 0);
         run_block(2'b01, 0, 2, ov_acc, done);
         if (done) do_ack(1'b1);
      end
      do_abort();

      // Abort while a candidate arrives in CAPTURE
      do_start(2'b00, 4'd0, 16'd8, 1'b0);
      obs_q.delete();
      @(negedge HCLK); smp_valid = 1'b1; smp_ws = 1'b0; smp_data = 32'hE0;
      @(negedge HCLK); smp_data = 32'hE1; cfg_en = 1'b0;
      @(negedge HCLK); smp_valid = 1'b0; cfg_en = 1'b1;
      check_eq("t5.fifo_wr", fifo_wr, 1'b0);
      check_eq("t5.busy", busy, 1'b0);
      check_eq("t5.i2s_en", i2s_en, 1'b0);
      check_eq("t5.no_writes", obs_q.size(), 0);

      // Invalid starts stay in IDLE
      @(negedge HCLK); cfg_blk_len = 16'd0; start = 1'b1;
      @(negedge HCLK); start = 1'b0;
      check_eq("t6.blk0_busy", busy, 1'b0);
      @(negedge HCLK); cfg_blk_len = 16'd3; cfg_en = 1'b0; start = 1'b1;
      @(negedge HCLK); start = 1'b0; cfg_en = 1'b1;
      check_eq("t6.en0_busy", busy, 1'b0);

      // Reset in the middle of a block
      do_start(2'b00, 4'd0, 16'd8, 1'b0);
      clear_stream();
      push_smp(1'b0, 32'hF0, 1'b0);
      push_smp(1'b0, 32'hF1, 1'b1);
      push_smp(1'b0, 32'hF2, 1'b0);
      push_smp(1'b0, 32'hF3, 1'b0);
      ov_acc = 0;
      run_block(2'b00, 0, 8, ov_acc, done);
      @(negedge HCLK); HRESET = 1'b1;
      @(negedge HCLK); HRESET = 1'b0;
      check_idle_outputs("t6.hreset");

      // Randomised sessions
      for (int it = 0; it < 25; it++) begin
         ch = 2'($urandom);
         dc = $urandom_range(0, 3);
         bl = $urandom_range(1, 6);
         cont = 1'($urandom);
         pfull = ($urandom_range(0, 1) == 1) ? 25 : 0;
         do_start(ch, 4'(dc), 16'(bl), cont);
         ov_acc = 0;
         for (int r = 0; r < (cont ? 2 : 1); r++) begin
            gen_random(bl * (dc + 1) * 2 + 6 + $urandom_range(0, 6), pfull);
            run_block(ch, dc, bl, ov_acc, done);
            if (!done) break;
            do_ack(cont);
         end
         do_abort();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
